intersection_ctrl: RTL and testbench
====================================

# intersection_ctrl

Four-way traffic-light sequencer for the intersection design. Runs off CLOCK_50 with its own 1 s prescaler, steps NS/EW signal heads through green → yellow → all-red phases, and grants pedestrian walk intervals on request. A pending cross-street request can end a green early once its minimum green has elapsed. It also drives the seconds-remaining value shown on the HEX display.

## Interface
- TICKS_PER_SEC, 50_000_000: clock cycles per second tick.
- GREEN_S, 10: full green duration (s), 1–15.
- MIN_GREEN_S, 4: minimum green before early termination, 1 ≤ MIN_GREEN_S ≤ GREEN_S.
- YELLOW_S, 3: yellow duration (s), 1–15.
- ALL_RED_S, 1: all-red clearance (s), 1–15.
- WALK_S, 4: walk interval (s), 1 ≤ WALK_S ≤ MIN_GREEN_S.
- CLOCK_50  in  1  system clock; the only clock.
- resetn  in  1  synchronous, active-low reset.
- ped_req_ns  in  1  active-high pedestrian request to walk alongside NS traffic; level or pulse, pre-synchronised.
- ped_req_ew  in  1  as above, EW.
- ns_light  out  3  {red, yellow, green}, one-hot.
- ew_light  out  3  {red, yellow, green}, one-hot.
- walk_ns  out  1  NS walk signal.
- walk_ew  out  1  EW walk signal.
- sec_left  out  4  seconds remaining in current phase (HEX digit).
- sec_tick  out  1  one-cycle pulse each second.

## Operation
- Prescaler: count 0..TICKS_PER_SEC-1, free-running; sec_tick = 1 when count == TICKS_PER_SEC-1; wraps to 0.
- States: RED_INIT → NS_GREEN → NS_YELLOW → RED_NS2EW → EW_GREEN → EW_YELLOW → RED_EW2NS → NS_GREEN …
- On phase entry, timer is loaded with the phase duration (ALL_RED_S, GREEN_S, YELLOW_S). Each sec_tick decrements the timer. A tick with timer == 1 advances the state, so a phase lasts exactly N ticks.
- Early termination: in X_GREEN, a tick where pend_Y == 1 (Y the cross direction) and elapsed ≥ MIN_GREEN_S goes to X_YELLOW. elapsed = GREEN_S − timer + 1, counting the current tick.
- Pedestrian latch: pend_X is set on any cycle ped_req_X == 1 and cleared on the edge entering X_GREEN. That edge also sets walk_en_X = pend_X | ped_req_X, so a same-cycle request is served. A request raised while in X_GREEN stays pending for the next X_GREEN.
- walk_X = 1 while state == X_GREEN, walk_en_X == 1 and elapsed ≤ WALK_S; otherwise 0.
- Lights decode from the state register (Moore). Red in RED_* states and on the non-green side; yellow in X_YELLOW.
- sec_left = timer.

## Timing
- Reset (resetn low at a CLOCK_50 edge):
  - state = RED_INIT, timer = ALL_RED_S, prescaler = 0.
  - pend_* = walk_en_* = 0.
  - Outputs: ns_light = ew_light = 3'b100, walk_* = 0, sec_tick = 0, sec_left = ALL_RED_S.
- Reset mid-phase aborts immediately. The next cycle shows the reset values; no yellow is shown first.
- State, timer and lights change on the edge where sec_tick == 1. Outputs reflect the new state in the following cycle; there is no additional latency.
- No state ever has both directions non-red.
- sec_left is never 0 outside reset, and is at most 15.

## Structure
- Shared package intersection_pkg:
  - state encoding (3-bit localparams);
  - light codes RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  - TICKS_PER_SEC default.
- Sub-module sec_tick_gen (prescaler: CLOCK_50, resetn → sec_tick); reusable by the display logic.
- Parameter legality is checked at elaboration; illegal values are a fatal error.

## Test plan
All scenarios use TICKS_PER_SEC = 4 and default parameters.
- Reset and basic cycle, no requests:
  - after reset, both red for 4 cycles;
  - NS green for 40 cycles, yellow 12, all-red 4;
  - EW green 40; period 112 cycles;
  - sec_left counts 10..1 in green.
- ped_req_ns pulsed during RED_INIT → walk_ns high for the first 16 cycles of NS_GREEN, then low; pend_ns clears at NS_GREEN entry.
- ped_req_ew pulsed 2 s into NS_GREEN → NS_YELLOW entered on the 4th tick of green (16 cycles, sec_left 7 → yellow 3). The following EW_GREEN shows walk_ew for 4 s.
- ped_req_ew pulsed 6 s into NS_GREEN → yellow on the next tick, i.e. NS_GREEN lasts 7 s.
- ped_req_ns asserted in the same cycle as NS_GREEN entry → walk_ns asserted from the first NS_GREEN cycle.
- resetn low for 1 cycle during EW_YELLOW → next cycle both red, sec_left = 1, walk and pending requests cleared. The sequence restarts with NS_GREEN after 4 cycles.

Source files
------------

// File: rtl/intersection_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : intersection_pkg
//  Purpose  : Shared types and constants for the intersection light sequencer:
//             phase encoding, one-hot light codes and light decode helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package intersection_pkg;

  // Default number of CLOCK_50 cycles per one-second tick.
  localparam int DEF_TICKS_PER_SEC = 50_000_000;

  // One-hot signal-head codes, {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Phase encoding (3-bit). Code 3'd7 is unused and recovers to ST_RED_INIT.
  typedef enum logic [2:0] {
    ST_RED_INIT  = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_RED_NS2EW = 3'd3,
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_RED_EW2NS = 3'd6
  } state_t;

  // NS signal head for a given phase; red whenever NS does not own the road.
  function automatic logic [2:0] ns_light_of(input state_t s);
    case (s)
      ST_NS_GREEN:  return GRN;
      ST_NS_YELLOW: return YEL;
      default:      return RED;
    endcase
  endfunction

  // EW signal head for a given phase; red whenever EW does not own the road.
  function automatic logic [2:0] ew_light_of(input state_t s);
    case (s)
      ST_EW_GREEN:  return GRN;
      ST_EW_YELLOW: return YEL;
      default:      return RED;
    endcase
  endfunction

endpackage : intersection_pkg
`default_nettype wire

// File: rtl/intersection_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : intersection_ctrl_if
//  Purpose  : Pedestrian request inputs and light/display outputs of the
//             intersection sequencer. The slave side is the controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface intersection_ctrl_if;

  logic       ped_req_ns;
  logic       ped_req_ew;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk_ns;
  logic       walk_ew;
  logic [3:0] sec_left;
  logic       sec_tick;

  // Environment side: raises requests, observes lights and display.
  modport master (
    output ped_req_ns, ped_req_ew,
    input  ns_light, ew_light, walk_ns, walk_ew, sec_left, sec_tick
  );

  // Controller side.
  modport slave (
    input  ped_req_ns, ped_req_ew,
    output ns_light, ew_light, walk_ns, walk_ew, sec_left, sec_tick
  );

endinterface : intersection_ctrl_if
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sec_tick_gen
//  Purpose  : Free-running prescaler 0..TICKS_PER_SEC-1 producing a one-cycle
//             pulse on the last count of every second.
//  Revision : 1.0 - initial release
// ============================================================================
module sec_tick_gen
  import intersection_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
  input  logic CLOCK_50,
  input  logic resetn,
  output logic sec_tick
);

  localparam int             CW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0]  C_LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] r_count;

  // Prescaler counter: wraps to zero on the tick cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Tick is a pure decode of the count register, so it is glitch-free and
  // low straight out of reset.
  assign sec_tick = (r_count == C_LAST);

endmodule : sec_tick_gen
`default_nettype wire

// File: rtl/intersection_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : intersection_ctrl
//  Purpose  : Four-way traffic-light sequencer. Steps NS/EW heads through
//             green -> yellow -> all-red, grants pedestrian walk intervals and
//             ends a green early for a pending cross-street request once the
//             minimum green has elapsed. Exposes seconds left for the display.
//  Revision : 1.0 - initial release
// ============================================================================
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int GREEN_S       = 10,
  parameter int MIN_GREEN_S   = 4,
  parameter int YELLOW_S      = 3,
  parameter int ALL_RED_S     = 1,
  parameter int WALK_S        = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  intersection_ctrl_if.slave bus
);

  // Refuse to build with durations that do not fit the 4-bit display digit
  // or that break the walk <= min-green <= green ordering.
  if (TICKS_PER_SEC < 1 ||
      GREEN_S < 1 || GREEN_S > 15 ||
      MIN_GREEN_S < 1 || MIN_GREEN_S > GREEN_S ||
      YELLOW_S < 1 || YELLOW_S > 15 ||
      ALL_RED_S < 1 || ALL_RED_S > 15 ||
      WALK_S < 1 || WALK_S > MIN_GREEN_S) begin : g_bad_params
    $fatal(1, "intersection_ctrl: illegal timing parameters");
  end

  localparam logic [3:0] C_GREEN   = 4'(GREEN_S);
  localparam logic [3:0] C_YELLOW  = 4'(YELLOW_S);
  localparam logic [3:0] C_ALL_RED = 4'(ALL_RED_S);
  localparam logic [4:0] C_ELAPSED_BASE = 5'(GREEN_S) + 5'd1;
  localparam logic [4:0] C_MIN_GREEN    = 5'(MIN_GREEN_S);
  localparam logic [4:0] C_WALK         = 5'(WALK_S);

  logic       w_sec_tick;

  state_t     r_state;
  logic [3:0] r_timer;
  logic       r_pend_ns;
  logic       r_pend_ew;
  logic       r_walk_en_ns;
  logic       r_walk_en_ew;
  logic [2:0] r_ns_light;
  logic [2:0] r_ew_light;
  logic       r_walk_ns;
  logic       r_walk_ew;

  state_t     w_state_nxt;
  logic [3:0] w_timer_nxt;
  logic       w_pend_ns_nxt;
  logic       w_pend_ew_nxt;
  logic       w_walk_en_ns_nxt;
  logic       w_walk_en_ew_nxt;
  logic [4:0] w_elapsed;
  logic [4:0] w_elapsed_nxt;
  logic       w_walk_ns_nxt;
  logic       w_walk_ew_nxt;

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .sec_tick (w_sec_tick)
  );

  // Seconds of green used so far, counting the current second. Only
  // meaningful in a green phase, where timer never exceeds GREEN_S.
  assign w_elapsed     = C_ELAPSED_BASE - {1'b0, r_timer};
  assign w_elapsed_nxt = C_ELAPSED_BASE - {1'b0, w_timer_nxt};

  // Next phase, timer and pedestrian bookkeeping for the coming edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_pend_ns_nxt    = r_pend_ns | bus.ped_req_ns;
    w_pend_ew_nxt    = r_pend_ew | bus.ped_req_ew;
    w_walk_en_ns_nxt = r_walk_en_ns;
    w_walk_en_ew_nxt = r_walk_en_ew;

    if (w_sec_tick) begin
      w_timer_nxt = r_timer - 4'd1;
      case (r_state)
        ST_RED_INIT, ST_RED_EW2NS: begin
          if (r_timer == 4'd1) begin
            w_state_nxt = ST_NS_GREEN;
            w_timer_nxt = C_GREEN;
          end
        end
        ST_NS_GREEN: begin
          if (r_timer == 4'd1 || (r_pend_ew && w_elapsed >= C_MIN_GREEN)) begin
            w_state_nxt = ST_NS_YELLOW;
            w_timer_nxt = C_YELLOW;
          end
        end
        ST_NS_YELLOW: begin
          if (r_timer == 4'd1) begin
            w_state_nxt = ST_RED_NS2EW;
            w_timer_nxt = C_ALL_RED;
          end
        end
        ST_RED_NS2EW: begin
          if (r_timer == 4'd1) begin
            w_state_nxt = ST_EW_GREEN;
            w_timer_nxt = C_GREEN;
          end
        end
        ST_EW_GREEN: begin
          if (r_timer == 4'd1 || (r_pend_ns && w_elapsed >= C_MIN_GREEN)) begin
            w_state_nxt = ST_EW_YELLOW;
            w_timer_nxt = C_YELLOW;
          end
        end
        ST_EW_YELLOW: begin
          if (r_timer == 4'd1) begin
            w_state_nxt = ST_RED_EW2NS;
            w_timer_nxt = C_ALL_RED;
          end
        end
        default: begin
          w_state_nxt = ST_RED_INIT;
          w_timer_nxt = C_ALL_RED;
        end
      endcase
    end

    // Entering a green serves whatever was pending plus a same-cycle request;
    // requests made later in that green wait for the next one.
    if (w_state_nxt == ST_NS_GREEN && r_state != ST_NS_GREEN) begin
      w_pend_ns_nxt    = 1'b0;
      w_walk_en_ns_nxt = r_pend_ns | bus.ped_req_ns;
    end
    if (w_state_nxt == ST_EW_GREEN && r_state != ST_EW_GREEN) begin
      w_pend_ew_nxt    = 1'b0;
      w_walk_en_ew_nxt = r_pend_ew | bus.ped_req_ew;
    end
  end

  // Walk is shown only during the opening WALK_S seconds of its green.
  assign w_walk_ns_nxt = (w_state_nxt == ST_NS_GREEN) && w_walk_en_ns_nxt &&
                         (w_elapsed_nxt <= C_WALK);
  assign w_walk_ew_nxt = (w_state_nxt == ST_EW_GREEN) && w_walk_en_ew_nxt &&
                         (w_elapsed_nxt <= C_WALK);

  // Phase register with outputs registered from the next-phase values, so
  // the heads follow the phase without an extra cycle of latency.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state      <= ST_RED_INIT;
      r_timer      <= C_ALL_RED;
      r_pend_ns    <= 1'b0;
      r_pend_ew    <= 1'b0;
      r_walk_en_ns <= 1'b0;
      r_walk_en_ew <= 1'b0;
      r_ns_light   <= RED;
      r_ew_light   <= RED;
      r_walk_ns    <= 1'b0;
      r_walk_ew    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_pend_ns    <= w_pend_ns_nxt;
      r_pend_ew    <= w_pend_ew_nxt;
      r_walk_en_ns <= w_walk_en_ns_nxt;
      r_walk_en_ew <= w_walk_en_ew_nxt;
      r_ns_light   <= ns_light_of(w_state_nxt);
      r_ew_light   <= ew_light_of(w_state_nxt);
      r_walk_ns    <= w_walk_ns_nxt;
      r_walk_ew    <= w_walk_ew_nxt;
    end
  end

  assign bus.ns_light = r_ns_light;
  assign bus.ew_light = r_ew_light;
  assign bus.walk_ns  = r_walk_ns;
  assign bus.walk_ew  = r_walk_ew;
  assign bus.sec_left = r_timer;
  assign bus.sec_tick = w_sec_tick;

endmodule : intersection_ctrl
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intersection_ctrl
//  Purpose  : Directed self-checking bench for intersection_ctrl with a
//             4-cycle second and default phase durations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_ctrl;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  logic clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;
  int   cur      = 0;

  intersection_ctrl_if bus ();

  intersection_ctrl #(
    .TICKS_PER_SEC (4)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to cycle c counted from the last reset edge.
  task automatic goto(input int c);
    tick(c - cur);
    cur = c;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    tick(n);
    cur    = 0;
    resetn = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                            input logic wns, input logic wew, input logic [3:0] sl);
    string t;
    t = $sformatf("%s@%0d", tag, cur);
    chk({t, ".ns_light"}, {5'd0, bus.ns_light}, {5'd0, ns});
    chk({t, ".ew_light"}, {5'd0, bus.ew_light}, {5'd0, ew});
    chk({t, ".walk_ns"},  {7'd0, bus.walk_ns},  {7'd0, wns});
    chk({t, ".walk_ew"},  {7'd0, bus.walk_ew},  {7'd0, wew});
    chk({t, ".sec_left"}, {4'd0, bus.sec_left}, {4'd0, sl});
  endtask

  initial begin
    bus.ped_req_ns = 1'b0;
    bus.ped_req_ew = 1'b0;

    // Basic cycle, no requests.
    do_reset(3);
    expect_out("s1.reset", L_R, L_R, 0, 0, 4'd1);
    chk("s1.reset.sec_tick", {7'd0, bus.sec_tick}, 8'd0);
    goto(2);   chk("s1.c2.sec_tick", {7'd0, bus.sec_tick}, 8'd0);
    goto(3);   expect_out("s1.red_init_end", L_R, L_R, 0, 0, 4'd1);
    chk("s1.c3.sec_tick", {7'd0, bus.sec_tick}, 8'd1);
    goto(4);   expect_out("s1.ns_green", L_G, L_R, 0, 0, 4'd10);
    chk("s1.c4.sec_tick", {7'd0, bus.sec_tick}, 8'd0);
    goto(7);   expect_out("s1.ns_green", L_G, L_R, 0, 0, 4'd10);
    goto(8);   expect_out("s1.ns_green", L_G, L_R, 0, 0, 4'd9);
    goto(43);  expect_out("s1.ns_green_last", L_G, L_R, 0, 0, 4'd1);
    goto(44);  expect_out("s1.ns_yellow", L_Y, L_R, 0, 0, 4'd3);
    goto(55);  expect_out("s1.ns_yellow_last", L_Y, L_R, 0, 0, 4'd1);
    goto(56);  expect_out("s1.red_ns2ew", L_R, L_R, 0, 0, 4'd1);
    goto(60);  expect_out("s1.ew_green", L_R, L_G, 0, 0, 4'd10);
    goto(99);  expect_out("s1.ew_green_last", L_R, L_G, 0, 0, 4'd1);
    goto(100); expect_out("s1.ew_yellow", L_R, L_Y, 0, 0, 4'd3);
    goto(112); expect_out("s1.red_ew2ns", L_R, L_R, 0, 0, 4'd1);
    goto(116); expect_out("s1.ns_green2", L_G, L_R, 0, 0, 4'd10);

    // NS request during RED_INIT: walk for the first 4 s of NS green only.
    do_reset(2);
    goto(1);   bus.ped_req_ns = 1'b1;
    goto(2);   bus.ped_req_ns = 1'b0;
    goto(4);   expect_out("s2.walk_start", L_G, L_R, 1, 0, 4'd10);
    goto(19);  expect_out("s2.walk_last", L_G, L_R, 1, 0, 4'd7);
    goto(20);  expect_out("s2.walk_off", L_G, L_R, 0, 0, 4'd6);
    goto(43);  expect_out("s2.ns_full_green", L_G, L_R, 0, 0, 4'd1);
    goto(60);  expect_out("s2.ew_green", L_R, L_G, 0, 0, 4'd10);
    goto(99);  expect_out("s2.ew_no_early_end", L_R, L_G, 0, 0, 4'd1);
    goto(116); expect_out("s2.pend_cleared", L_G, L_R, 0, 0, 4'd10);

    // EW request 2 s into NS green: yellow after the 4th green second.
    do_reset(2);
    goto(12);  expect_out("s3.pre_req", L_G, L_R, 0, 0, 4'd8);
    bus.ped_req_ew = 1'b1;
    goto(13);  bus.ped_req_ew = 1'b0;
    goto(19);  expect_out("s3.green_last", L_G, L_R, 0, 0, 4'd7);
    goto(20);  expect_out("s3.early_yellow", L_Y, L_R, 0, 0, 4'd3);
    goto(32);  expect_out("s3.red_ns2ew", L_R, L_R, 0, 0, 4'd1);
    goto(36);  expect_out("s3.ew_walk", L_R, L_G, 0, 1, 4'd10);
    goto(51);  expect_out("s3.ew_walk_last", L_R, L_G, 0, 1, 4'd7);
    goto(52);  expect_out("s3.ew_walk_off", L_R, L_G, 0, 0, 4'd6);

    // EW request 6 s into NS green: yellow on the next tick.
    do_reset(2);
    goto(28);  expect_out("s4.pre_req", L_G, L_R, 0, 0, 4'd4);
    bus.ped_req_ew = 1'b1;
    goto(29);  bus.ped_req_ew = 1'b0;
    goto(31);  expect_out("s4.green_last", L_G, L_R, 0, 0, 4'd4);
    goto(32);  expect_out("s4.early_yellow", L_Y, L_R, 0, 0, 4'd3);

    // NS request in the same cycle as NS green entry.
    do_reset(2);
    goto(3);   bus.ped_req_ns = 1'b1;
    goto(4);   bus.ped_req_ns = 1'b0;
    expect_out("s5.same_cycle", L_G, L_R, 1, 0, 4'd10);
    goto(19);  expect_out("s5.walk_last", L_G, L_R, 1, 0, 4'd7);
    goto(20);  expect_out("s5.walk_off", L_G, L_R, 0, 0, 4'd6);

    // One-cycle reset during EW yellow with an NS request pending.
    do_reset(2);
    goto(101); expect_out("s6.ew_yellow", L_R, L_Y, 0, 0, 4'd3);
    bus.ped_req_ns = 1'b1;
    goto(102); bus.ped_req_ns = 1'b0;
    goto(104); expect_out("s6.pre_reset", L_R, L_Y, 0, 0, 4'd2);
    do_reset(1);
    expect_out("s6.after_reset", L_R, L_R, 0, 0, 4'd1);
    chk("s6.after_reset.sec_tick", {7'd0, bus.sec_tick}, 8'd0);
    goto(3);   expect_out("s6.red_init_end", L_R, L_R, 0, 0, 4'd1);
    goto(4);   expect_out("s6.restart_no_walk", L_G, L_R, 0, 0, 4'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_intersection_ctrl
`default_nettype wire
